arp_lookup_arbiter: RTL and testbench

- Shares one ARP lookup engine among NUM_REQ requesters using round-robin arbitration.
- Typical requesters: per-port main state machines plus the CPU/register path.
- Sits between the requesters' arp_lookup_req/done/search_ip/result_mac interfaces and the single ARP table lookup engine.
- Sequences the engine handshake, latches the search IP and result, and enforces a timeout so a stalled engine cannot hang the forwarding path.

---
 rtl/arp_lookup_arbiter_if.sv | 19 +
 rtl/arp_lookup_arbiter.sv | 118 +++++++++++
 tb/tb_arp_lookup_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/arp_lookup_arbiter_if.sv
// arp_lookup_arbiter_if: requester-side and engine-side lookup handshake bundle
interface arp_lookup_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*32-1:0] req_search_ip;
  logic [NUM_REQ-1:0]    done;
  logic [47:0]           result_mac;
  logic                  arp_lookup_req;
  logic [31:0]           arp_lookup_search_ip;
  logic                  arp_lookup_done;
  logic [47:0]           arp_lookup_result_mac;
  modport master (
    output req, req_search_ip, arp_lookup_done, arp_lookup_result_mac,
    input  done, result_mac, arp_lookup_req, arp_lookup_search_ip
  );
  modport slave (
    input  req, req_search_ip, arp_lookup_done, arp_lookup_result_mac,
    output done, result_mac, arp_lookup_req, arp_lookup_search_ip
  );
endinterface

// File: rtl/arp_lookup_arbiter.sv
// arp_lookup_arbiter: round-robin sharing of one ARP lookup engine with a stall timeout
module arp_lookup_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  arp_lookup_arbiter_if.slave bus,
  output logic                busy,
  output logic [2:0]          grant_id,
  output logic                cntr_arp_lookups,
  output logic                cntr_arp_timeouts
);
  localparam logic [3:0]  NR    = 4'(NUM_REQ);
  localparam logic [15:0] TLAST = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
  state_t             state, state_n;
  logic [2:0]         rr_ptr, rr_n, grant_n, win;
  logic [15:0]        cnt, cnt_n;
  logic [NUM_REQ-1:0] mask, mask_n, elig, tmp, done_n, gnt_oh;
  logic [31:0]        ip_n;
  logic [47:0]        mac_n;
  logic [3:0]         sum;
  logic               found, lreq_n, lk_n, to_n;

  // rotate the eligible set so bit 0 is rr_ptr; the lowest set bit is the winner
  always_comb begin
    elig = bus.req & ~mask;
    tmp = (elig >> rr_ptr) | (elig << (NR - 4'(rr_ptr)));
    found = 1'b0;
    sum = '0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && tmp[0]) begin
        found = 1'b1;
        sum = 4'(rr_ptr) + 4'(k);
        win = 3'(sum >= NR ? sum - NR : sum);
      end
      tmp = tmp >> 1;
    end
  end

  // next state plus next value of every registered output
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    grant_n = grant_id;
    cnt_n = cnt;
    mask_n = mask;
    ip_n = bus.arp_lookup_search_ip;
    mac_n = bus.result_mac;
    done_n = '0;
    lreq_n = bus.arp_lookup_req;
    lk_n = 1'b0;
    to_n = 1'b0;
    gnt_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    case (state)
      IDLE: begin
        mask_n = '0;
        if (found) begin
          state_n = ISSUE;
          grant_n = win;
          rr_n = (4'(win) + 4'd1 == NR) ? 3'd0 : win + 3'd1;
          ip_n = 32'(bus.req_search_ip >> {win, 5'd0});
          cnt_n = '0;
          lreq_n = 1'b1;
        end
      end
      ISSUE: begin
        cnt_n = cnt + 16'd1;
        if (bus.arp_lookup_done || cnt == TLAST) begin
          state_n = RESPOND;
          lreq_n = 1'b0;
          done_n = gnt_oh;
          lk_n = 1'b1;
          to_n = !bus.arp_lookup_done;
          mac_n = bus.arp_lookup_done ? bus.arp_lookup_result_mac : '0;
        end
      end
      RESPOND: begin
        mask_n = gnt_oh;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state and output registers; reset aborts any lookup without a done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant_id <= '0;
      cnt <= '0;
      mask <= '0;
      busy <= 1'b0;
      cntr_arp_lookups <= 1'b0;
      cntr_arp_timeouts <= 1'b0;
      bus.done <= '0;
      bus.result_mac <= '0;
      bus.arp_lookup_req <= 1'b0;
      bus.arp_lookup_search_ip <= '0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      grant_id <= grant_n;
      cnt <= cnt_n;
      mask <= mask_n;
      busy <= state_n != IDLE;
      cntr_arp_lookups <= lk_n;
      cntr_arp_timeouts <= to_n;
      bus.done <= done_n;
      bus.result_mac <= mac_n;
      bus.arp_lookup_req <= lreq_n;
      bus.arp_lookup_search_ip <= ip_n;
    end
  end
endmodule

// File: tb/tb_arp_lookup_arbiter.sv
// tb_arp_lookup_arbiter: directed checks of arbitration order, engine handshake, timeout and reset abort
module tb_arp_lookup_arbiter;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         busy, cntr_arp_lookups, cntr_arp_timeouts;
  logic [2:0]   grant_id;
  int           n_tests = 0;
  int           n_fail = 0;
  int           r_wait, r_hi;
  logic [2:0]   r_gid;
  logic [N-1:0] r_done;
  logic [47:0]  r_mac;
  logic [31:0]  r_ip;
  logic         r_lk, r_to;
  logic [N+1:0] acc;

  arp_lookup_arbiter_if #(.NUM_REQ(N)) bus ();

  arp_lookup_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .grant_id(grant_id),
    .cntr_arp_lookups(cntr_arp_lookups),
    .cntr_arp_timeouts(cntr_arp_timeouts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req = '0;
    bus.arp_lookup_done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // acts as the engine: answers in the lat-th cycle of arp_lookup_req (0 = never), returns in the done cycle
  task automatic lookup(input int lat, input logic [47:0] mac);
    r_wait = 0;
    while (!bus.arp_lookup_req && r_wait < 20) begin
      step();
      r_wait++;
    end
    r_ip = bus.arp_lookup_search_ip;
    r_gid = grant_id;
    r_hi = 0;
    while (bus.arp_lookup_req && r_hi < 100) begin
      r_hi++;
      bus.arp_lookup_done = (lat != 0 && r_hi == lat);
      bus.arp_lookup_result_mac = mac;
      step();
    end
    bus.arp_lookup_done = 1'b0;
    r_done = bus.done;
    r_mac = bus.result_mac;
    r_lk = cntr_arp_lookups;
    r_to = cntr_arp_timeouts;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_search_ip = {32'hC0A80004, 32'hC0A80003, 32'h0A000002, 32'hC0A80001};
    bus.arp_lookup_result_mac = '0;
    do_reset();
    check("rst_ctrl", {bus.done, bus.arp_lookup_req, busy, grant_id, cntr_arp_lookups, cntr_arp_timeouts}, 0);
    check("rst_mac", bus.result_mac, 0);
    check("rst_ip", bus.arp_lookup_search_ip, 0);
    // single requester 1, engine answers after 3 cycles
    bus.req = 4'b0010;
    lookup(3, 48'h001122334455);
    check("t1_wait", r_wait, 1);
    check("t1_ip", r_ip, 32'h0A000002);
    check("t1_gid", r_gid, 1);
    check("t1_hi", r_hi, 3);
    check("t1_done", r_done, 4'b0010);
    check("t1_mac", r_mac, 48'h001122334455);
    check("t1_lk", r_lk, 1);
    check("t1_to", r_to, 0);
    bus.req = '0;
    step();
    check("t1_done_1cyc", {bus.done, cntr_arp_lookups}, 0);
    // simultaneous requesters 0 and 2 out of reset
    do_reset();
    bus.req = 4'b0101;
    lookup(2, 48'h0000000000A0);
    check("t2_gid0", r_gid, 0);
    check("t2_done0", r_done, 4'b0001);
    check("t2_ip0", r_ip, 32'hC0A80001);
    bus.req = 4'b0100;
    lookup(1, 48'h0000000000A2);
    check("t2_gid1", r_gid, 2);
    check("t2_done1", r_done, 4'b0100);
    check("t2_ip1", r_ip, 32'hC0A80003);
    check("t2_mac1", r_mac, 48'h0000000000A2);
    // all four requesting continuously
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      lookup(1, 48'(i + 1));
      check($sformatf("t3_gid%0d", i), r_gid, 64'(i % 4));
      check($sformatf("t3_done%0d", i), r_done, 4'b0001 << (i % 4));
    end
    // engine never answers: forced miss after 8 cycles, late done ignored
    bus.req = 4'b0001;
    lookup(0, 48'hDEADBEEF0001);
    check("t4_gid", r_gid, 0);
    check("t4_hi", r_hi, 8);
    check("t4_done", r_done, 4'b0001);
    check("t4_mac", r_mac, 0);
    check("t4_lk", r_lk, 1);
    check("t4_to", r_to, 1);
    bus.req = '0;
    acc = '0;
    repeat (3) begin
      step();
      acc = acc | {bus.done, cntr_arp_lookups, busy};
    end
    bus.arp_lookup_done = 1'b1;
    bus.arp_lookup_result_mac = 48'h0123456789AB;
    step();
    bus.arp_lookup_done = 1'b0;
    repeat (3) begin
      acc = acc | {bus.done, cntr_arp_lookups, busy};
      step();
    end
    check("t4_late_ignored", acc, 0);
    check("t4_late_mac", bus.result_mac, 0);
    // engine done in the same cycle as the timeout hit: done wins
    bus.req = 4'b0100;
    lookup(8, 48'h00000000C0DE);
    check("t4b_hi", r_hi, 8);
    check("t4b_mac", r_mac, 48'h00000000C0DE);
    check("t4b_to", r_to, 0);
    check("t4b_done", r_done, 4'b0100);
    // requester 3 holds req past its done: masked for one IDLE cycle
    bus.req = 4'b1000;
    lookup(1, 48'hAABBCCDDEEFF);
    check("t5_gid", r_gid, 3);
    check("t5_done", r_done, 4'b1000);
    step();
    check("t5_idle0_busy", busy, 0);
    step();
    check("t5_masked_busy", busy, 0);
    step();
    check("t5_regrant_busy", busy, 1);
    check("t5_regrant_gid", grant_id, 3);
    lookup(2, 48'h0000000000AB);
    check("t5_regrant_done", r_done, 4'b1000);
    check("t5_regrant_mac", r_mac, 48'h0000000000AB);
    bus.req = '0;
    // reset in the second ISSUE cycle
    step();
    bus.req = 4'b0010;
    step();
    check("t6_issue1", {bus.arp_lookup_req, grant_id}, {1'b1, 3'd1});
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req = '0;
    check("t6_rst_ctrl", {bus.done, bus.arp_lookup_req, busy, grant_id, cntr_arp_lookups, cntr_arp_timeouts}, 0);
    check("t6_rst_mac", bus.result_mac, 0);
    check("t6_rst_ip", bus.arp_lookup_search_ip, 0);
    step();
    check("t6_no_done", bus.done, 0);
    bus.req = 4'b0101;
    lookup(1, 48'h000000000001);
    check("t6_gid0", r_gid, 0);
    bus.req = 4'b0100;
    lookup(1, 48'h000000000002);
    check("t6_gid1", r_gid, 2);
    check("t6_done1", r_done, 4'b0100);
    bus.req = '0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
